// File: rtl/debouncer_pkg.sv
// ---------------------------------------------------------------------------
// debouncer_pkg
// Shared types and helpers for the per-bit debounce filter.
//   debounce_state_t   : per-channel FSM state (STABLE / COUNTING)
//   debounce_cnt_width : width of a counter that can hold 0..cycles
// ---------------------------------------------------------------------------
package debouncer_pkg;

    typedef enum logic {
        DB_STABLE   = 1'b0,
        DB_COUNTING = 1'b1
    } debounce_state_t;

    // Wide enough to count up to 'cycles' without wrapping.
    function automatic int debounce_cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// ---------------------------------------------------------------------------
// debounce_channel
// Single-bit debounce filter: the output level follows the input only after
// the input has held the opposite level for DEBOUNCE_CYCLES consecutive clocks.
// Optional macro DEBOUNCER_EDGE_EN builds registered rise/fall pulses;
// without it o_rise/o_fall are tied low and no edge flops exist.
// Ports:
//   clk         : system clock
//   n_rst       : asynchronous active-low reset
//   i_sync_data : synchronized (not debounced) input bit
//   o_data      : debounced level
//   o_busy      : 1 while a candidate change is being qualified
//   o_rise      : 1-cycle pulse when o_data goes 0->1
//   o_fall      : 1-cycle pulse when o_data goes 1->0
// ---------------------------------------------------------------------------
module debounce_channel
    import debouncer_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = 16,
    parameter logic RESET_VAL       = 1'b0
) (
    input  logic clk,
    input  logic n_rst,
    input  logic i_sync_data,
    output logic o_data,
    output logic o_busy,
    output logic o_rise,
    output logic o_fall
);

    localparam int             CNT_W    = debounce_cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    // Count value at which the next differing sample is the accepting one.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    debounce_state_t  r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_data;
    logic             r_busy;

    debounce_state_t  w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_data_nxt;
    logic             w_differs;

    assign w_differs = i_sync_data ^ r_data;

    // Next-state, counter and accepted-level decode.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = CNT_ZERO;
        w_data_nxt  = r_data;
        case (r_state)
            DB_STABLE: begin
                if (w_differs) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        // A single differing sample is already enough.
                        w_data_nxt  = i_sync_data;
                        w_state_nxt = DB_STABLE;
                    end else begin
                        w_state_nxt = DB_COUNTING;
                        w_cnt_nxt   = CNT_ONE;
                    end
                end else begin
                    w_state_nxt = DB_STABLE;
                end
            end
            DB_COUNTING: begin
                if (!w_differs) begin
                    // Bounce back to the held level: discard the partial count.
                    w_state_nxt = DB_STABLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_data_nxt  = i_sync_data;
                    w_state_nxt = DB_STABLE;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = DB_STABLE;
            end
        endcase
    end

    // State, counter, level and busy registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= DB_STABLE;
            r_cnt   <= CNT_ZERO;
            r_data  <= RESET_VAL;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_data  <= w_data_nxt;
            r_busy  <= (w_state_nxt == DB_COUNTING);
        end
    end

    assign o_data = r_data;
    assign o_busy = r_busy;

`ifdef DEBOUNCER_EDGE_EN
    logic r_rise;
    logic r_fall;

    // Edge pulses land in the same cycle the new level appears on o_data.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_rise <= w_data_nxt & ~r_data;
            r_fall <= ~w_data_nxt & r_data;
        end
    end

    assign o_rise = r_rise;
    assign o_fall = r_fall;
`else
    assign o_rise = 1'b0;
    assign o_fall = 1'b0;
`endif

endmodule

// File: rtl/debouncer.sv
// ---------------------------------------------------------------------------
// debouncer
// DATA_WIDTH independent debounce channels for inputs already synchronized
// into the clk domain. Optional macro DEBOUNCER_EDGE_EN enables o_rise/o_fall;
// when undefined those ports stay present and read 0.
// Ports:
//   clk         : system clock
//   n_rst       : asynchronous active-low reset
//   i_sync_data : synchronized (not debounced) inputs
//   o_data      : debounced levels
//   o_busy      : per bit, 1 while that channel qualifies a change
//   o_rise      : per bit, 1-cycle pulse on accepted 0->1
//   o_fall      : per bit, 1-cycle pulse on accepted 1->0
// ---------------------------------------------------------------------------
module debouncer
    import debouncer_pkg::*;
#(
    parameter int                    DATA_WIDTH      = 1,
    parameter int                    DEBOUNCE_CYCLES = 16,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL       = {DATA_WIDTH{1'b0}}
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic [DATA_WIDTH-1:0] i_sync_data,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [DATA_WIDTH-1:0] o_busy,
    output logic [DATA_WIDTH-1:0] o_rise,
    output logic [DATA_WIDTH-1:0] o_fall
);

    for (genvar g = 0; g < DATA_WIDTH; g++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_VAL       (RESET_VAL[g])
        ) u_channel (
            .clk         (clk),
            .n_rst       (n_rst),
            .i_sync_data (i_sync_data[g]),
            .o_data      (o_data[g]),
            .o_busy      (o_busy[g]),
            .o_rise      (o_rise[g]),
            .o_fall      (o_fall[g])
        );
    end

endmodule

// File: tb/tb_debouncer.sv
module tb_debouncer;

`ifdef DEBOUNCER_EDGE_EN
    localparam bit EDGE_ON = 1'b1;
`else
    localparam bit EDGE_ON = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       n_rst;
    logic [1:0] a_din, a_data, a_busy, a_rise, a_fall;
    logic [0:0] b_din, b_data, b_busy, b_rise, b_fall;

    debouncer #(.DATA_WIDTH(2), .DEBOUNCE_CYCLES(4), .RESET_VAL(2'b01)) u_dut_a (
        .clk(clk), .n_rst(n_rst), .i_sync_data(a_din),
        .o_data(a_data), .o_busy(a_busy), .o_rise(a_rise), .o_fall(a_fall)
    );

    debouncer #(.DATA_WIDTH(1), .DEBOUNCE_CYCLES(1), .RESET_VAL(1'b0)) u_dut_b (
        .clk(clk), .n_rst(n_rst), .i_sync_data(b_din),
        .o_data(b_data), .o_busy(b_busy), .o_rise(b_rise), .o_fall(b_fall)
    );

    typedef struct {
        logic [1:0] din;
        logic [1:0] data;
        logic [1:0] busy;
        logic [1:0] rise;
        logic [1:0] fall;
    } vec_t;

    vec_t tbl[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check2(input string name, input logic [1:0] act, input logic [1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Edge expectations collapse to 0 when the edge feature is not built.
    task automatic check_a(input string tag, input logic [1:0] d, input logic [1:0] b,
                           input logic [1:0] r, input logic [1:0] f);
        check2({tag, " data"}, a_data, d);
        check2({tag, " busy"}, a_busy, b);
        check2({tag, " rise"}, a_rise, EDGE_ON ? r : 2'b00);
        check2({tag, " fall"}, a_fall, EDGE_ON ? f : 2'b00);
    endtask

    function automatic void add(input logic [1:0] din, input logic [1:0] d, input logic [1:0] b,
                                input logic [1:0] r, input logic [1:0] f);
        tbl.push_back('{din, d, b, r, f});
    endfunction

    task automatic step_a(input logic [1:0] din);
        a_din = din;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] b_pat;
        logic       b_prev;

        // ---- table: din, data, busy, rise, fall (DUT A, 4 cycles, reset 01)
        for (int i = 0; i < 3; i++) add(2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
        // clean fall of bit0
        for (int i = 0; i < 3; i++) add(2'b00, 2'b01, 2'b01, 2'b00, 2'b00);
        add(2'b00, 2'b00, 2'b00, 2'b00, 2'b01);
        add(2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        // clean rise of bit0
        for (int i = 0; i < 3; i++) add(2'b01, 2'b00, 2'b01, 2'b00, 2'b00);
        add(2'b01, 2'b01, 2'b00, 2'b01, 2'b00);
        add(2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
        // bounce on bit1: 1,1,1,0,1,1,1,1
        for (int i = 0; i < 3; i++) add(2'b11, 2'b01, 2'b10, 2'b00, 2'b00);
        add(2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
        for (int i = 0; i < 3; i++) add(2'b11, 2'b01, 2'b10, 2'b00, 2'b00);
        add(2'b11, 2'b11, 2'b00, 2'b10, 2'b00);
        add(2'b11, 2'b11, 2'b00, 2'b00, 2'b00);
        // prepare: bit0 to 0
        for (int i = 0; i < 3; i++) add(2'b10, 2'b11, 2'b01, 2'b00, 2'b00);
        add(2'b10, 2'b10, 2'b00, 2'b00, 2'b01);
        // independent: bit0 rises, bit1 falls two cycles later
        add(2'b11, 2'b10, 2'b01, 2'b00, 2'b00);
        add(2'b11, 2'b10, 2'b01, 2'b00, 2'b00);
        add(2'b01, 2'b10, 2'b11, 2'b00, 2'b00);
        add(2'b01, 2'b11, 2'b10, 2'b01, 2'b00);
        add(2'b01, 2'b11, 2'b10, 2'b00, 2'b00);
        add(2'b01, 2'b01, 2'b00, 2'b00, 2'b10);
        add(2'b01, 2'b01, 2'b00, 2'b00, 2'b00);

        // ---- reset
        n_rst = 1'b0;
        a_din = 2'b01;
        b_din = 1'b0;
        #12;
        check_a("in_reset", 2'b01, 2'b00, 2'b00, 2'b00);
        check2("b in_reset data", {1'b0, b_data}, 2'b00);
        @(posedge clk);
        #1;
        check_a("in_reset_edge", 2'b01, 2'b00, 2'b00, 2'b00);
        n_rst = 1'b1;

        // ---- table-driven vectors
        foreach (tbl[i]) begin
            step_a(tbl[i].din);
            check_a($sformatf("vec%0d", i), tbl[i].data, tbl[i].busy, tbl[i].rise, tbl[i].fall);
        end

        // ---- reset mid-count: move off RESET_VAL first so the reset is visible
        for (int i = 0; i < 3; i++) begin
            step_a(2'b11);
            check_a($sformatf("mid_pre%0d", i), 2'b01, 2'b10, 2'b00, 2'b00);
        end
        step_a(2'b11);
        check_a("mid_accept", 2'b11, 2'b00, 2'b10, 2'b00);
        for (int i = 0; i < 3; i++) begin
            step_a(2'b10);
            check_a($sformatf("mid_cnt%0d", i), 2'b11, 2'b01, 2'b00, 2'b00);
        end
        #1;
        n_rst = 1'b0;
        #1;
        check_a("mid_async_reset", 2'b01, 2'b00, 2'b00, 2'b00);
        #2;
        n_rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step_a(2'b10);
            check_a($sformatf("post_rst%0d", i), 2'b01, 2'b11, 2'b00, 2'b00);
        end
        step_a(2'b10);
        check_a("post_rst_accept", 2'b10, 2'b00, 2'b10, 2'b01);
        step_a(2'b10);
        check_a("post_rst_hold", 2'b10, 2'b00, 2'b00, 2'b00);

        // ---- DUT B: one-cycle debounce follows the input with one cycle of latency
        b_pat  = 8'b1011_0010;
        b_prev = 1'b0;
        for (int i = 0; i < 8; i++) begin
            b_din = b_pat[i];
            @(posedge clk);
            #1;
            check2($sformatf("b%0d data", i), {1'b0, b_data}, {1'b0, b_pat[i]});
            check2($sformatf("b%0d busy", i), {1'b0, b_busy}, 2'b00);
            check2($sformatf("b%0d rise", i), {1'b0, b_rise},
                   {1'b0, EDGE_ON & b_pat[i] & ~b_prev});
            check2($sformatf("b%0d fall", i), {1'b0, b_fall},
                   {1'b0, EDGE_ON & ~b_pat[i] & b_prev});
            b_prev = b_pat[i];
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/debouncer.md
Name: debouncer

Overview:
- Per-bit debounce filter that consumes the outputs of the multi-flop synchronizer (buttons, switches, external status pins) already in the `clk` domain.
- A bit's filtered output changes only after its input has held the new value for DEBOUNCE_CYCLES consecutive clocks.
- Optionally emits single-cycle rise/fall pulses for downstream control logic.

Parameters:
- DATA_WIDTH, 1, number of independent channels
- DEBOUNCE_CYCLES, 16, consecutive differing samples needed to accept a new level; must be >= 1
- RESET_VAL, 0 (DATA_WIDTH bits), reset value of o_data; must match the upstream synchronizer's reset value

Ports:
- clk  input  1  system clock
- n_rst  input  1  asynchronous active-low reset
- i_sync_data  input  DATA_WIDTH  synchronized (not debounced) input
- o_data  output  DATA_WIDTH  debounced level
- o_busy  output  DATA_WIDTH  per bit: 1 while that channel is counting a candidate change
- o_rise  output  DATA_WIDTH  per bit: 1-cycle pulse when o_data goes 0->1 (needs DEBOUNCER_EDGE_EN)
- o_fall  output  DATA_WIDTH  per bit: 1-cycle pulse when o_data goes 1->0 (needs DEBOUNCER_EDGE_EN)

Behaviour:
- Interface: one clock `clk`; reset `n_rst` is asynchronous, active-low. All flops use it.
- Reset values:
  - o_data = RESET_VAL
  - o_busy, o_rise, o_fall = 0
  - all counters = 0, all channels in STABLE
- Channels are fully independent; each has its own FSM and counter.
- Counter width: CNT_W = $clog2(DEBOUNCE_CYCLES+1). The counter never exceeds DEBOUNCE_CYCLES, so it never wraps.
- Per-channel FSM (two states, registered):
  - STABLE:
    - i_sync_data[b] == o_data[b]: stay, cnt = 0.
    - Differs and DEBOUNCE_CYCLES == 1: o_data[b] takes the input this edge, stay STABLE.
    - Differs otherwise: go COUNTING, cnt = 1.
  - COUNTING:
    - Input equals o_data[b] again (bounce): go STABLE, cnt = 0, o_data unchanged.
    - Still differs and cnt+1 == DEBOUNCE_CYCLES: o_data[b] <= i_sync_data[b], cnt = 0, go STABLE.
    - Still differs otherwise: cnt <= cnt+1.
- Latency: o_data[b] updates on the DEBOUNCE_CYCLES-th consecutive rising edge that samples the differing value. With DEBOUNCE_CYCLES = 1 this is one cycle of latency.
- o_busy[b] is registered and equals (state == COUNTING).
- Any single sample equal to o_data[b] restarts qualification from zero. Glitches shorter than DEBOUNCE_CYCLES never propagate.
- Single-bit data: "differs" always means the opposite level, so no intermediate values exist.
- Edge pulses:
  - Registered; asserted in the same cycle o_data[b] changes; deasserted next cycle unless a new change is accepted.
  - Back-to-back accepted changes are possible only with DEBOUNCE_CYCLES == 1.
- Reset mid-count: the channel returns immediately to STABLE / RESET_VAL and the partial count is discarded. After release, a differing input requires the full DEBOUNCE_CYCLES again.
- Simultaneous changes on several bits are handled independently, with no cross-channel ordering.

Optional Feature:
- Macro: DEBOUNCER_EDGE_EN.
- Defined: o_rise/o_fall are generated as above, using one extra DATA_WIDTH-bit register pair.
- Undefined: o_rise and o_fall are tied to 0, no edge flops are built, and the ports stay present so instantiations are unchanged.

Decomposition:
- Shared package debouncer_pkg:
  - typedef enum logic {DB_STABLE, DB_COUNTING} debounce_state_t
  - function debounce_cnt_width(int cycles) returning $clog2(cycles+1)
- Sub-module debounce_channel: single bit, holding the FSM, counter, o_data bit, o_busy bit and the optional edge flops.
- debouncer instantiates DATA_WIDTH copies in a generate loop. The parent has no other logic.

Test Plan:
- Reset: DATA_WIDTH=2, RESET_VAL=2'b01, DEBOUNCE_CYCLES=4, input 2'b01 through and after reset -> o_data=2'b01, o_busy=0, o_rise=o_fall=0 throughout.
- Clean change: DEBOUNCE_CYCLES=4, bit0 steps 0->1 and holds -> o_busy[0]=1 for 3 cycles; o_data[0]=1 after the 4th edge sampling 1; o_rise[0] high exactly 1 cycle, coincident with that change.
- Bounce rejection: input pattern 1,1,1,0,1,1,1,1 against o_data=0 -> no change at sample 3; o_data goes 1 only after sample 7 (4 consecutive 1s); no pulse at the glitch.
- Independent channels: bit0 rises while bit1 falls 2 cycles later, both held -> o_data[0] changes 2 cycles before o_data[1]; o_rise[0] and o_fall[1] are each single pulses.
- Reset mid-count: assert n_rst with cnt=3 of 4 -> outputs immediately RESET_VAL/0; after release with the input still differing, the change is accepted only after 4 more edges.
- Edge macro off and DEBOUNCE_CYCLES=1: rebuild without DEBOUNCER_EDGE_EN, toggle input every cycle -> o_data follows the input delayed 1 cycle; o_rise/o_fall stay 0.
